// File: rtl/univ_shift_reg_seq.sv
// univ_shift_reg_seq: WIDTH-bit universal shift register running COUNT steps per start, with busy/done handshake; rotate modes need USR_ROTATE_EN.
module univ_shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             lsi,
    input  logic             rsi,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] qout,
    output logic             lso,
    output logic             rso,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [2:0]       mode_r;
    logic [2:0]       cur_mode;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] nxt;
    logic             multi;
    assign lso      = qout[WIDTH-1];
    assign rso      = qout[0];
    assign cur_mode = state == RUN ? mode_r : mode;
`ifdef USR_ROTATE_EN
    assign multi = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
`else
    assign multi = mode inside {3'b001, 3'b010, 3'b110};
`endif
    // single-step result of the active op; unlisted codes hold
    always_comb begin
        nxt = qout;
        case (cur_mode)
            3'b001:  nxt = {rsi, qout[WIDTH-1:1]};
            3'b010:  nxt = {qout[WIDTH-2:0], lsi};
            3'b011:  nxt = din;
`ifdef USR_ROTATE_EN
            3'b100:  nxt = {qout[0], qout[WIDTH-1:1]};
            3'b101:  nxt = {qout[WIDTH-2:0], qout[WIDTH-1]};
`endif
            3'b110:  nxt = {qout[WIDTH-1], qout[WIDTH-1:1]};
            3'b111:  nxt = '0;
            default: nxt = qout;
        endcase
    end
    // IDLE accepts an op and does its first step; RUN finishes the remaining steps
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            qout      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            mode_r    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mode_r <= mode;
                    if (!multi || count != '0) qout <= nxt;
                    if (multi && count > CNT_W'(1)) begin
                        busy      <= 1'b1;
                        remaining <= count - CNT_W'(1);
                        state     <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    qout      <= nxt;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// tb_univ_shift_reg_seq: scoreboard bench for univ_shift_reg_seq, follows USR_ROTATE_EN.
module tb_univ_shift_reg_seq;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, lsi = 1'b0, rsi = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] count = '0;
    logic [7:0] din = '0;
    logic [7:0] qout;
    logic       lso, rso, busy, done;
    int         checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mq = '0;
`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    univ_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .count(count),
        .lsi(lsi), .rsi(rsi), .din(din), .qout(qout), .lso(lso), .rso(rso),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_step(input logic [2:0] m, input logic [7:0] v,
                                              input logic l, input logic r, input logic [7:0] d);
        case (m)
            3'd1: return (v >> 1) | ({7'd0, r} << 7);
            3'd2: return (v << 1) | {7'd0, l};
            3'd3: return d;
            3'd4: return ROT ? ((v >> 1) | (v << 7)) : v;
            3'd5: return ROT ? ((v << 1) | (v >> 7)) : v;
            3'd6: return 8'($signed(v) >>> 1);
            3'd7: return 8'h00;
            default: return v;
        endcase
    endfunction

    function automatic bit is_multi(input logic [2:0] m);
        return m == 3'd1 || m == 3'd2 || m == 3'd6 || (ROT && (m == 3'd4 || m == 3'd5));
    endfunction

    task automatic drive(input logic [2:0] m, input logic [3:0] c, input logic [7:0] d,
                         input logic l, input logic r);
        mode = m; count = c; din = d; lsi = l; rsi = r; start = 1'b1;
        if (!is_multi(m)) mq = model_step(m, mq, l, r, d);
        else for (int i = 0; i < int'(c); i++) mq = model_step(m, mq, l, r, d);
        exp_q.push_back(mq);
    endtask

    task automatic run_op(input string name, input logic [2:0] m, input logic [3:0] c,
                          input logic [7:0] d, input logic l, input logic r,
                          input logic [7:0] want, input bit poke);
        int busy_n = 0;
        int exp_busy;
        bit seen = 1'b0;
        logic [7:0] e;
        @(negedge clk);
        drive(m, c, d, l, r);
        exp_busy = (is_multi(m) && c > 4'd1) ? int'(c) - 1 : 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && i == 1) begin
                start = 1'b1; mode = 3'd3; din = 8'h5A; count = 4'd1;
            end
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done: never seen within 40 cycles, required a pulse", name);
        end
        checks++;
        if (qout !== e) begin
            failures++;
            $display("FAIL %s qout: got %h expected %h", name, qout, e);
        end
        checks++;
        if (qout !== want) begin
            failures++;
            $display("FAIL %s qout_const: got %h expected %h", name, qout, want);
        end
        checks++;
        if (busy_n != exp_busy || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: cycles %0d (busy now %b) expected %0d (busy now 0)", name, busy_n, busy, exp_busy);
        end
        checks++;
        if (lso !== qout[7] || rso !== qout[0]) begin
            failures++;
            $display("FAIL %s taps: lso=%b rso=%b expected %b %b", name, lso, rso, qout[7], qout[0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s done_width: got %b expected 0 one cycle later", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (qout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset: qout=%h busy=%b done=%b expected 00 0 0", qout, busy, done);
        end
        reset = 1'b1;
        mq = '0;
    endtask

    task automatic test_abort();
        int pulses = 0;
        run_op("abort_load", 3'd3, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        @(negedge clk);
        drive(3'd1, 4'd10, 8'h00, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy: got %b expected 1 mid-run", busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (qout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: qout=%h busy=%b done=%b expected 00 0 0", qout, busy, done);
        end
        reset = 1'b1;
        mq = '0;
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        logic [7:0] e;
        @(negedge clk);
        drive(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || qout !== e) begin
            failures++;
            $display("FAIL b2b_first: done=%b qout=%h expected 1 %h", done, qout, e);
        end
        drive(3'd2, 4'd3, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: done=%b busy=%b expected 0 1", done, busy);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen || qout !== e || qout !== 8'hE7) begin
            failures++;
            $display("FAIL b2b_second: seen=%b qout=%h expected 1 %h (E7)", seen, qout, e);
        end
    endtask

    task automatic test_no_rotate_busy();
        bit was_busy = 1'b0;
        @(negedge clk);
        drive(3'd4, 4'd5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        was_busy = busy;
        void'(exp_q.pop_front());
        checks++;
        if (!ROT && (was_busy !== 1'b0 || done !== 1'b1 || qout !== mq)) begin
            failures++;
            $display("FAIL ror_disabled: busy=%b done=%b qout=%h expected 0 1 %h", was_busy, done, qout, mq);
        end
        else if (ROT && was_busy !== 1'b1) begin
            failures++;
            $display("FAIL ror_enabled_busy: got %b expected 1", was_busy);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_abort();
        run_op("load_a5", 3'd3, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
        run_op("load_81", 3'd3, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        run_op("shr3", 3'd1, 4'd3, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0);
        run_op("load_81b", 3'd3, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
        run_op("rol9", 3'd5, 4'd9, 8'h00, 1'b0, 1'b0, ROT ? 8'h03 : 8'h81, 1'b0);
        run_op("load_80", 3'd3, 4'd0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0);
        run_op("asr4_poke", 3'd6, 4'd4, 8'h00, 1'b0, 1'b0, 8'hF8, 1'b1);
        run_op("shl0", 3'd2, 4'd0, 8'h00, 1'b1, 1'b0, 8'hF8, 1'b0);
        run_op("ror5", 3'd4, 4'd5, 8'h00, 1'b0, 1'b0, ROT ? 8'hC7 : 8'hF8, 1'b0);
        run_op("shl12", 3'd2, 4'd12, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0);
        run_op("shr1", 3'd1, 4'd1, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("clr", 3'd7, 4'd6, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
        run_op("hold", 3'd0, 4'd3, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
        test_back_to_back();
        test_no_rotate_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
